nf_reg_dump: RTL

Debug read-out engine for the nanoFOX register file. On a start pulse it walks the register file's debug read port (ra0/rd0) from the first selected register to the last. It captures each register value and streams it out as an index/data word over a valid/ready handshake. It sits between the core's register file (debug build) and a debug transport such as a UART or JTAG bridge.

---
 rtl/nf_reg_dump_if.sv | 9 +
 rtl/nf_reg_dump.sv | 58 +++++
 2 files changed

// File: rtl/nf_reg_dump_if.sv
// nf_reg_dump_if: index/data word stream from the register dump engine to a debug transport
interface nf_reg_dump_if;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  modport master(output out_data, out_idx, out_valid, input out_ready);
  modport slave(input out_data, out_idx, out_valid, output out_ready);
endinterface

// File: rtl/nf_reg_dump.sv
// nf_reg_dump: walks the register-file debug port and streams each register as an index/data word
module nf_reg_dump #(
  parameter int NUM_REGS = 32,
  parameter int SKIP_X0  = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  output logic [4:0]         ra0,
  input  logic [31:0]        rd0,
  nf_reg_dump_if.master      dump,
  output logic               busy,
  output logic               done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [4:0] FIRST = (SKIP_X0 != 0) ? 5'd1 : 5'd0;
  localparam logic [4:0] LAST  = 5'(NUM_REGS - 1);
  logic [1:0]  state, state_nx;
  logic [4:0]  idx;
  logic [31:0] data_q;
  logic [4:0]  idx_q;
  logic        hs;
  assign dump.out_valid = state == SEND;
  assign dump.out_data  = data_q;
  assign dump.out_idx   = idx_q;
  assign ra0  = (state == IDLE) ? 5'd0 : idx;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // a handshake coinciding with abort is not an acceptance
  assign hs = dump.out_valid & dump.out_ready & ~abort;
  always_comb begin
    state_nx = abort ? IDLE :
               (state == IDLE) ? (start ? READ : IDLE) :
               (state == READ) ? SEND :
               (state == SEND) ? (hs ? ((idx == LAST) ? DONE : READ) : SEND) :
               IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      idx    <= 5'd0;
      data_q <= 32'd0;
      idx_q  <= 5'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && !abort) idx <= FIRST;
      if (state == SEND && hs && idx != LAST) idx <= idx + 5'd1;
      if (state == READ) begin
        data_q <= rd0;
        idx_q  <= idx;
      end
    end
  end
endmodule
